// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the digital-clock timekeeping slice: mode encodings,
// field limits and widths, and the mode-sequencing helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  function automatic mode_e mode_after(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_RUN:      nxt = MODE_SET_HOUR;
      MODE_SET_HOUR: nxt = MODE_SET_MIN;
      MODE_SET_MIN:  nxt = MODE_SET_SEC;
      MODE_SET_SEC:  nxt = MODE_RUN;
      default:       nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Bundle of timebase, button and display signals around the time controller.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic              sec_lvl;
  logic              gen_rst;
  logic              btn_mode;
  logic              btn_inc;
  logic              btn_dec;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic [1:0]        mode;
  logic              blink;

  modport slave (
    input  sec_lvl, btn_mode, btn_inc, btn_dec,
    output gen_rst, hour, min, sec, mode, blink
  );

  modport master (
    output sec_lvl, btn_mode, btn_inc, btn_dec,
    input  gen_rst, hour, min, sec, mode, blink
  );

endinterface

// File: rtl/clock_time_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up/down counter with a same-cycle carry on increment wrap,
// so chained fields roll over together on one edge.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk_100mhz,
  input  logic             rst_100mhz,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_r;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s  = (value_r == MAX_V);
  assign at_zero_s = (value_r == {WIDTH{1'b0}});
  // Opposing requests cancel, so carry needs inc alone.
  assign carry     = inc & ~dec & ~clr & at_max_s;
  assign value     = value_r;

  // Field register with wrap in both directions.
  always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
    if (rst_100mhz) begin
      value_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      value_r <= {WIDTH{1'b0}};
    end else if (inc && !dec) begin
      value_r <= at_max_s ? {WIDTH{1'b0}} : value_r + WIDTH'(1);
    end else if (dec && !inc) begin
      value_r <= at_zero_s ? MAX_V : value_r - WIDTH'(1);
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller: counts 1 Hz toggles in RUN, edits
// fields in set modes, holds the timebase generator in reset while editing.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF = 25_000_000,
  parameter int HOUR_MAX   = 23
) (
  input logic              clk_100mhz,
  input logic              rst_100mhz,
  clock_time_ctrl_if.slave bus
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  mode_e          state_r;
  mode_e          next_state_s;
  logic           sec_lvl_q_r;
  logic           gen_rst_r;
  logic           blink_r;
  logic [BW-1:0]  blink_cnt_r;

  logic tick_s, run_s, edit_inc_s, edit_dec_s, press_s;
  logic sec_inc_s, sec_dec_s, min_inc_s, min_dec_s, hour_inc_s, hour_dec_s;
  logic sec_carry_s, min_carry_s;

  assign tick_s     = bus.sec_lvl ^ sec_lvl_q_r;
  assign run_s      = (state_r == MODE_RUN);
  // A mode press or a simultaneous inc+dec suppresses the edit.
  assign edit_inc_s = ~run_s & ~bus.btn_mode & bus.btn_inc & ~bus.btn_dec;
  assign edit_dec_s = ~run_s & ~bus.btn_mode & bus.btn_dec & ~bus.btn_inc;
  assign press_s    = bus.btn_inc | bus.btn_dec;

  assign sec_inc_s  = (run_s & tick_s) | ((state_r == MODE_SET_SEC) & edit_inc_s);
  assign sec_dec_s  = (state_r == MODE_SET_SEC) & edit_dec_s;
  assign min_inc_s  = (run_s & sec_carry_s) | ((state_r == MODE_SET_MIN) & edit_inc_s);
  assign min_dec_s  = (state_r == MODE_SET_MIN) & edit_dec_s;
  assign hour_inc_s = (run_s & min_carry_s) | ((state_r == MODE_SET_HOUR) & edit_inc_s);
  assign hour_dec_s = (state_r == MODE_SET_HOUR) & edit_dec_s;

  // Next mode: each press advances one step around the ring.
  always_comb begin
    next_state_s = state_r;
    if (bus.btn_mode) begin
      next_state_s = mode_after(state_r);
    end else begin
      next_state_s = state_r;
    end
  end

  // Mode register, generator hold and second-edge history.
  always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
    if (rst_100mhz) begin
      state_r     <= MODE_RUN;
      gen_rst_r   <= 1'b0;
      sec_lvl_q_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      gen_rst_r   <= (next_state_s != MODE_RUN);
      sec_lvl_q_r <= bus.sec_lvl;
    end
  end

  // Edit-field blink: restarts on mode change or press so edits stay visible.
  always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
    if (rst_100mhz) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (run_s || (next_state_s != state_r) || press_s) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
      blink_r     <= blink_r;
    end
  end

  wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (sec_inc_s),
    .dec        (sec_dec_s),
    .clr        (1'b0),
    .value      (bus.sec),
    .carry      (sec_carry_s)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (min_inc_s),
    .dec        (min_dec_s),
    .clr        (1'b0),
    .value      (bus.min),
    .carry      (min_carry_s)
  );

  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (hour_inc_s),
    .dec        (hour_dec_s),
    .clr        (1'b0),
    .value      (bus.hour),
    .carry      ()
  );

  assign bus.mode    = state_r;
  assign bus.gen_rst = gen_rst_r;
  assign bus.blink   = blink_r;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: time-of-day reference model plus
// directed scenarios with literal expectations.
module tb_clock_time_ctrl;

  localparam int BH = 4;
  localparam int HM = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(.BLINK_HALF(BH), .HOUR_MAX(HM)) dut (
    .clk_100mhz (clk),
    .rst_100mhz (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time of day as seconds since midnight, blink as the
  // number of undisturbed cycles spent in the current edit mode.
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_phase = 0;
  int m_next, m_t, m_d;
  bit m_sl = 1'b0, m_gen = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_phase = 0; m_sl = 1'b0; m_gen = 1'b0;
    end else begin
      m_next = bus.btn_mode ? (m_mode + 1) % 4 : m_mode;
      if (m_mode == 0 && bus.sec_lvl != m_sl) begin
        m_t = (m_h * 3600 + m_m * 60 + m_s + 1) % ((HM + 1) * 3600);
        m_h = m_t / 3600;
        m_m = (m_t / 60) % 60;
        m_s = m_t % 60;
      end
      m_sl = bus.sec_lvl;
      if (m_mode != 0 && !bus.btn_mode && (bus.btn_inc != bus.btn_dec)) begin
        m_d = bus.btn_inc ? 1 : -1;
        case (m_mode)
          1:       m_h = (m_h + m_d + HM + 1) % (HM + 1);
          2:       m_m = (m_m + m_d + 60) % 60;
          default: m_s = (m_s + m_d + 60) % 60;
        endcase
      end
      if (m_next != m_mode || m_mode == 0 || bus.btn_inc || bus.btn_dec) m_phase = 0;
      else m_phase++;
      m_mode = m_next;
      m_gen  = (m_next != 0);
    end
  end

  // Every-cycle comparison against the model, well after the active edge.
  always begin
    @(posedge clk);
    #2;
    check("hour",    bus.hour,    m_h);
    check("min",     bus.min,     m_m);
    check("sec",     bus.sec,     m_s);
    check("mode",    bus.mode,    m_mode);
    check("gen_rst", bus.gen_rst, int'(m_gen));
    check("blink",   bus.blink,   (m_mode != 0 && ((m_phase / BH) % 2) == 1) ? 1 : 0);
  end

  task automatic toggle();
    @(negedge clk);
    bus.sec_lvl = ~bus.sec_lvl;
  endtask

  task automatic press(input bit pm, input bit pi, input bit pd);
    @(negedge clk);
    bus.btn_mode = pm; bus.btn_inc = pi; bus.btn_dec = pd;
    @(negedge clk);
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
  endtask

  initial begin
    bus.sec_lvl = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hour", bus.hour, 0);
    check("rst_sec",  bus.sec,  0);
    check("rst_mode", bus.mode, 0);
    check("rst_gen",  bus.gen_rst, 0);
    check("rst_blink", bus.blink, 0);

    // Three seconds counted in RUN.
    repeat (3) begin
      toggle();
      repeat (10) @(negedge clk);
    end
    check("t1_sec", bus.sec, 3);
    check("t1_min", bus.min, 0);
    check("t1_gen", bus.gen_rst, 0);

    // Preload 23:59:58 and roll over midnight.
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    repeat (5) press(0, 0, 1);
    press(1, 0, 0);
    check("t2_pre_hour", bus.hour, 23);
    check("t2_pre_sec",  bus.sec,  58);
    toggle();
    @(negedge clk);
    check("t2_sec59", bus.sec, 59);
    check("t2_min59", bus.min, 59);
    toggle();
    @(negedge clk);
    check("t2_wrap_hour", bus.hour, 0);
    check("t2_wrap_min",  bus.min,  0);
    check("t2_wrap_sec",  bus.sec,  0);

    // Set-hour entry ignores ticks; hour decrements below zero.
    press(1, 0, 0);
    check("t3_mode", bus.mode, 1);
    check("t3_gen",  bus.gen_rst, 1);
    repeat (4) begin
      toggle();
      repeat (3) @(negedge clk);
    end
    check("t3_sec_hold", bus.sec, 0);
    press(0, 0, 1);
    check("t3_hour23", bus.hour, 23);

    // Minute wraps without touching hour; inc+dec together ignored.
    press(1, 0, 0);
    press(0, 0, 1);
    check("t4_min59", bus.min, 59);
    press(0, 1, 0);
    check("t4_min0",  bus.min, 0);
    check("t4_hour",  bus.hour, 23);
    press(0, 1, 1);
    check("t4_both",  bus.min, 0);

    // Blink cadence in SET_SEC and restart on a press.
    press(1, 0, 0);
    repeat (3) @(negedge clk);
    check("t5_blink_lo", bus.blink, 0);
    @(negedge clk);
    check("t5_blink_hi", bus.blink, 1);
    press(0, 1, 0);
    check("t5_press_blink", bus.blink, 0);
    check("t5_press_sec",   bus.sec, 1);
    repeat (3) @(negedge clk);
    check("t5_restart_lo", bus.blink, 0);
    @(negedge clk);
    check("t5_restart_hi", bus.blink, 1);
    press(1, 0, 0);
    check("t5_run_blink", bus.blink, 0);
    check("t5_run_gen",   bus.gen_rst, 0);
    check("t5_run_mode",  bus.mode, 0);

    // Tick and mode press on the same edge: both take effect.
    @(negedge clk);
    bus.sec_lvl = ~bus.sec_lvl; bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    check("t6_tick_mode", bus.mode, 1);
    check("t6_tick_sec",  bus.sec, 2);
    repeat (11) press(0, 0, 1);
    press(1, 1, 0);
    check("t6_mode_wins", bus.hour, 12);
    repeat (34) press(0, 1, 0);
    press(1, 0, 0);
    repeat (6) press(0, 0, 1);
    press(1, 0, 0);
    press(1, 0, 0);
    check("t6_pre_hour", bus.hour, 12);
    check("t6_pre_min",  bus.min, 34);
    check("t6_pre_sec",  bus.sec, 56);
    check("t6_pre_mode", bus.mode, 1);

    // Asynchronous reset mid-cycle while editing.
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.sec_lvl = 1'b0;
    #1;
    check("t6_rst_hour", bus.hour, 0);
    check("t6_rst_min",  bus.min, 0);
    check("t6_rst_sec",  bus.sec, 0);
    check("t6_rst_mode", bus.mode, 0);
    check("t6_rst_gen",  bus.gen_rst, 0);
    check("t6_rst_blink", bus.blink, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_after_sec", bus.sec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping and time-set controller for the digital clock. Consumes the 1 Hz square wave from the timebase generator and keeps hours/minutes/seconds. Sequences the generator: holds it in reset while the user edits time, then releases it so the first second after editing is a full second. Sits between the timebase generator, the debounced button pulses, and the display driver.

Parameters:
BLINK_HALF, 25_000_000, clk cycles per half-period of the edit-field blink (use 4 in simulation)
HOUR_MAX, 23, highest hour value; rollover to 0 after it

Ports:
clk_100mhz  in  1  system clock, 100 MHz
rst_100mhz  in  1  asynchronous, active-high reset
sec_lvl  in  1  square wave from the timebase generator; each toggle marks one elapsed second
gen_rst  out  1  reset to the timebase generator, active-high
btn_mode  in  1  one-cycle pulse; cycles RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
btn_inc  in  1  one-cycle pulse; increments the edited field
btn_dec  in  1  one-cycle pulse; decrements the edited field
hour  out  5  current hour, binary 0..HOUR_MAX
min  out  6  current minute, binary 0..59
sec  out  6  current second, binary 0..59
mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
blink  out  1  1 = blank the edited field now; always 0 in RUN

Behaviour:
- Reset (async): state RUN; hour/min/sec = 0; gen_rst = 0; blink = 0; blink counter = 0; sec_lvl_q = 0.
- All outputs are registered.
- Tick detect: sec_lvl_q <= sec_lvl every cycle; tick = sec_lvl ^ sec_lvl_q. Both edges count. A tick is acted on only in RUN.
- RUN, tick: sec+1. At 59, sec wraps to 0 and carries to min. Min 59 wraps to 0 and carries to hour. Hour HOUR_MAX wraps to 0.
  - 23:59:59 + tick -> 00:00:00 in one cycle.
  - The count updates the cycle after the sec_lvl edge is sampled.
- FSM: btn_mode advances the state RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. It transitions on the next edge.
- gen_rst is registered and equals (next_state != RUN). It rises with entry into SET_HOUR and falls the same edge the state returns to RUN.
  - The generator's output falls to 0 while in set mode. That edge is ignored because ticks are not acted on outside RUN.
- Set modes: btn_inc/btn_dec modify only the selected field. Range wraps: hour 0<->HOUR_MAX, min and sec 0<->59. No carry or borrow into other fields.
- Simultaneous events:
  - btn_inc and btn_dec together: both ignored.
  - btn_mode with inc/dec: mode wins, inc/dec ignored.
  - RUN tick with btn_mode: the tick is counted and the state advances, both on the same edge.
- Blink: counter runs only in set modes and counts 0..BLINK_HALF-1.
  - blink toggles at wrap.
  - Counter and blink clear to 0 on any state change and in RUN.
  - Any inc/dec press clears the counter and forces blink = 0, so the edited value stays visible.
- Reset mid-edit: immediate return to RUN with 00:00:00 and gen_rst = 0.

Decomposition:
- Shared package clock_pkg:
  - mode encodings MODE_RUN/SET_HOUR/SET_MIN/SET_SEC
  - constants SEC_MAX=59, MIN_MAX=59
  - field widths 5/6/6
- One natural sub-module: wrap_counter.
  - Parameterised width and max.
  - Inputs: inc, dec, load-zero.
  - Outputs: value, carry-out on inc wrap.
  - Instantiated for sec, min and hour. Carry is used only in RUN.

Test Plan:
1. Reset, toggle sec_lvl 3 times, 10 cycles apart -> sec=3, min=0, hour=0, mode=0, gen_rst=0.
2. Preload 23:59:58 via set mode, return to RUN, toggle sec_lvl twice -> 23:59:59, then 00:00:00; no intermediate carry glitch.
3. Mode press -> mode=1 and gen_rst=1 next cycle. Toggle sec_lvl 4 times -> sec unchanged. btn_dec at hour=0 -> hour=23.
4. In SET_MIN at min=59: btn_inc -> min=0 and hour unchanged. btn_inc and btn_dec in the same cycle -> no change.
5. BLINK_HALF=4 in SET_SEC: blink toggles every 4 cycles. btn_inc mid-period -> blink=0 and counter restarts. Mode press to RUN -> blink=0, gen_rst=0 on the same edge.
6. Assert rst_100mhz asynchronously mid-cycle while in SET_HOUR at 12:34:56 -> all outputs 0 immediately, mode=RUN.
